// File: rtl/zone_input_conditioner.sv
// Zone sensor front end: two-flop synchroniser, per-zone tick-sampled debounce FSM,
// sticky trip latch with one-cycle trip pulse and first-tripped-zone capture.
module zone_input_conditioner #(
   parameter int NZONES       = 3,
   parameter int DEBOUNCE_CNT = 4,
   parameter int CNT_W        = 3,
   parameter int IDX_W        = 2
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iTICK,
   input  logic [NZONES-1:0] iZONE,
   input  logic [NZONES-1:0] iMASK,
   input  logic              iCLEAR,
   output logic [NZONES-1:0] oZONE_STABLE,
   output logic [NZONES-1:0] oZONE_LATCHED,
   output logic              oTRIP,
   output logic              oFIRST_VALID,
   output logic [IDX_W-1:0]  oFIRST_ZONE
);

   typedef enum logic [1:0] {IDLE, QUAL_ON, ACTIVE, QUAL_OFF} zone_state_t;

   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam bit               SINGLE   = (DEBOUNCE_CNT == 1);

   logic [NZONES-1:0] meta;
   logic [NZONES-1:0] sync;
   logic [NZONES-1:0] stable_vec;
   logic [NZONES-1:0] latched_next;
   logic [NZONES-1:0] new_bits;
   logic [IDX_W-1:0]  first_idx;

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= iZONE;
         sync <= meta;
      end
   end

   for (genvar z = 0; z < NZONES; z++) begin : g_zone
      zone_state_t      state, state_next;
      logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
      logic             stable;

      assign cnt_inc = cnt + CNT_ONE;

      // Counter holds the number of consecutive samples disagreeing with the stable level.
      always_comb begin
         state_next = state;
         cnt_next   = cnt;
         if (iTICK) begin
            case (state)
               IDLE: begin
                  if (sync[z]) begin
                     if (SINGLE) begin
                        state_next = ACTIVE;
                        cnt_next   = '0;
                     end else begin
                        state_next = QUAL_ON;
                        cnt_next   = CNT_ONE;
                     end
                  end
               end
               QUAL_ON: begin
                  if (!sync[z]) begin
                     state_next = IDLE;
                     cnt_next   = '0;
                  end else if (cnt_inc == CNT_DONE) begin
                     state_next = ACTIVE;
                     cnt_next   = '0;
                  end else begin
                     cnt_next = cnt_inc;
                  end
               end
               ACTIVE: begin
                  if (!sync[z]) begin
                     if (SINGLE) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                     end else begin
                        state_next = QUAL_OFF;
                        cnt_next   = CNT_ONE;
                     end
                  end
               end
               QUAL_OFF: begin
                  if (sync[z]) begin
                     state_next = ACTIVE;
                     cnt_next   = '0;
                  end else if (cnt_inc == CNT_DONE) begin
                     state_next = IDLE;
                     cnt_next   = '0;
                  end else begin
                     cnt_next = cnt_inc;
                  end
               end
               default: begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end
            endcase
         end
      end

      always_ff @(posedge iCLK or negedge iRST) begin
         if (!iRST) begin
            state  <= IDLE;
            cnt    <= '0;
            stable <= 1'b0;
         end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            stable <= (state_next == ACTIVE) || (state_next == QUAL_OFF);
         end
      end

      assign stable_vec[z] = stable;
   end

   assign oZONE_STABLE = stable_vec;

   // Level-based latch: a zone still stable after a clear re-latches on the following edge.
   assign latched_next = iCLEAR ? '0 : (oZONE_LATCHED | (oZONE_STABLE & ~iMASK));
   assign new_bits     = latched_next & ~oZONE_LATCHED;

   always_comb begin
      first_idx = '0;
      for (int i = NZONES - 1; i >= 0; i--) begin
         if (new_bits[i]) first_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         oZONE_LATCHED <= '0;
         oTRIP         <= 1'b0;
         oFIRST_VALID  <= 1'b0;
         oFIRST_ZONE   <= '0;
      end else begin
         oZONE_LATCHED <= latched_next;
         oTRIP         <= |new_bits;
         if (iCLEAR) begin
            oFIRST_VALID <= 1'b0;
            oFIRST_ZONE  <= '0;
         end else if (!oFIRST_VALID && (|new_bits)) begin
            oFIRST_VALID <= 1'b1;
            oFIRST_ZONE  <= first_idx;
         end
      end
   end

endmodule

// File: tb/tb_zone_input_conditioner.sv
// Directed bench for zone_input_conditioner: debounce, glitch rejection, latch/mask,
// clear/re-latch, first-zone capture and asynchronous reset mid-qualification.
module tb_zone_input_conditioner;

   logic       iCLK = 1'b0;
   logic       iRST = 1'b0;
   logic       iTICK = 1'b0;
   logic [2:0] iZONE = 3'b000;
   logic [2:0] iMASK = 3'b000;
   logic       iCLEAR = 1'b0;
   logic [2:0] oZONE_STABLE;
   logic [2:0] oZONE_LATCHED;
   logic       oTRIP;
   logic       oFIRST_VALID;
   logic [1:0] oFIRST_ZONE;

   int checks = 0;
   int failures = 0;
   int trip_count = 0;
   int t0 = 0;

   zone_input_conditioner #(
      .NZONES(3), .DEBOUNCE_CNT(4), .CNT_W(3), .IDX_W(2)
   ) dut (
      .iCLK(iCLK), .iRST(iRST), .iTICK(iTICK), .iZONE(iZONE), .iMASK(iMASK),
      .iCLEAR(iCLEAR), .oZONE_STABLE(oZONE_STABLE), .oZONE_LATCHED(oZONE_LATCHED),
      .oTRIP(oTRIP), .oFIRST_VALID(oFIRST_VALID), .oFIRST_ZONE(oFIRST_ZONE)
   );

   always #5 iCLK = ~iCLK;

   // Counts trip pulses, one count per cycle oTRIP is high.
   always @(posedge iCLK) begin
      #1;
      if (oTRIP) trip_count++;
   end

   task automatic gap(input int n);
      repeat (n) @(negedge iCLK);
   endtask

   task automatic do_tick();
      iTICK = 1'b1;
      @(negedge iCLK);
      iTICK = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         do_tick();
         gap(9);
      end
   endtask

   task automatic test_reset();
      iRST = 1'b0;
      gap(2);
      checks++;
      if ({oZONE_STABLE, oZONE_LATCHED, oTRIP, oFIRST_VALID, oFIRST_ZONE} !== 10'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=0", {oZONE_STABLE, oZONE_LATCHED, oTRIP, oFIRST_VALID, oFIRST_ZONE});
      end
      iRST = 1'b1;
      gap(2);
   endtask

   task automatic test_basic();
      iZONE = 3'b001;
      gap(3);
      ticks(3);
      checks++;
      if (oZONE_STABLE !== 3'b000) begin failures++; $display("FAIL basic_stable_early got=%b exp=000", oZONE_STABLE); end
      do_tick();
      checks++;
      if (oZONE_STABLE !== 3'b001) begin failures++; $display("FAIL basic_stable got=%b exp=001", oZONE_STABLE); end
      checks++;
      if (oZONE_LATCHED !== 3'b000) begin failures++; $display("FAIL basic_latch_early got=%b exp=000", oZONE_LATCHED); end
      t0 = trip_count;
      gap(1);
      checks++;
      if (oZONE_LATCHED !== 3'b001) begin failures++; $display("FAIL basic_latched got=%b exp=001", oZONE_LATCHED); end
      checks++;
      if (oTRIP !== 1'b1) begin failures++; $display("FAIL basic_trip got=%b exp=1", oTRIP); end
      checks++;
      if (oFIRST_VALID !== 1'b1 || oFIRST_ZONE !== 2'd0) begin
         failures++; $display("FAIL basic_first got=%b/%0d exp=1/0", oFIRST_VALID, oFIRST_ZONE);
      end
      gap(1);
      checks++;
      if (oTRIP !== 1'b0) begin failures++; $display("FAIL basic_trip_width got=%b exp=0", oTRIP); end
      checks++;
      if (trip_count - t0 !== 1) begin failures++; $display("FAIL basic_trip_count got=%0d exp=1", trip_count - t0); end
   endtask

   task automatic test_glitch();
      t0 = trip_count;
      iZONE = 3'b011;
      gap(3);
      ticks(3);
      iZONE = 3'b001;
      gap(3);
      ticks(4);
      checks++;
      if (oZONE_STABLE !== 3'b001) begin failures++; $display("FAIL glitch_stable got=%b exp=001", oZONE_STABLE); end
      checks++;
      if (oZONE_LATCHED !== 3'b001) begin failures++; $display("FAIL glitch_latched got=%b exp=001", oZONE_LATCHED); end
      checks++;
      if (trip_count !== t0) begin failures++; $display("FAIL glitch_trip got=%0d exp=%0d", trip_count, t0); end
      iZONE = 3'b000;
      gap(3);
      do_tick();
      checks++;
      if (oZONE_STABLE !== 3'b001) begin failures++; $display("FAIL dropout_hold got=%b exp=001", oZONE_STABLE); end
      iZONE = 3'b001;
      gap(3);
      ticks(4);
      checks++;
      if (oZONE_STABLE !== 3'b001) begin failures++; $display("FAIL dropout_recover got=%b exp=001", oZONE_STABLE); end
   endtask

   task automatic test_simultaneous();
      iZONE = 3'b000;
      gap(3);
      ticks(4);
      checks++;
      if (oZONE_STABLE !== 3'b000) begin failures++; $display("FAIL simul_off got=%b exp=000", oZONE_STABLE); end
      iCLEAR = 1'b1;
      gap(1);
      iCLEAR = 1'b0;
      gap(1);
      checks++;
      if (oZONE_LATCHED !== 3'b000 || oFIRST_VALID !== 1'b0) begin
         failures++; $display("FAIL simul_cleared got=%b/%b exp=000/0", oZONE_LATCHED, oFIRST_VALID);
      end
      t0 = trip_count;
      iZONE = 3'b110;
      gap(3);
      ticks(3);
      do_tick();
      gap(1);
      checks++;
      if (oZONE_LATCHED !== 3'b110) begin failures++; $display("FAIL simul_latched got=%b exp=110", oZONE_LATCHED); end
      checks++;
      if (oFIRST_VALID !== 1'b1 || oFIRST_ZONE !== 2'd1) begin
         failures++; $display("FAIL simul_first got=%b/%0d exp=1/1", oFIRST_VALID, oFIRST_ZONE);
      end
      gap(2);
      checks++;
      if (trip_count - t0 !== 1) begin failures++; $display("FAIL simul_one_trip got=%0d exp=1", trip_count - t0); end
      iZONE = 3'b111;
      gap(3);
      ticks(4);
      checks++;
      if (oZONE_LATCHED !== 3'b111) begin failures++; $display("FAIL later_latched got=%b exp=111", oZONE_LATCHED); end
      checks++;
      if (oFIRST_ZONE !== 2'd1) begin failures++; $display("FAIL later_first got=%0d exp=1", oFIRST_ZONE); end
      checks++;
      if (trip_count - t0 !== 2) begin failures++; $display("FAIL later_trip got=%0d exp=2", trip_count - t0); end
   endtask

   task automatic test_mask();
      iZONE = 3'b000;
      gap(3);
      ticks(4);
      iCLEAR = 1'b1;
      gap(1);
      iCLEAR = 1'b0;
      iMASK = 3'b100;
      iZONE = 3'b100;
      t0 = trip_count;
      gap(3);
      ticks(4);
      checks++;
      if (oZONE_STABLE !== 3'b100) begin failures++; $display("FAIL mask_stable got=%b exp=100", oZONE_STABLE); end
      checks++;
      if (oZONE_LATCHED !== 3'b000) begin failures++; $display("FAIL mask_latched got=%b exp=000", oZONE_LATCHED); end
      checks++;
      if (trip_count !== t0) begin failures++; $display("FAIL mask_trip got=%0d exp=%0d", trip_count, t0); end
      iMASK = 3'b000;
      gap(1);
      checks++;
      if (oZONE_LATCHED !== 3'b100 || oTRIP !== 1'b1) begin
         failures++; $display("FAIL unmask_latch got=%b/%b exp=100/1", oZONE_LATCHED, oTRIP);
      end
      checks++;
      if (oFIRST_ZONE !== 2'd2) begin failures++; $display("FAIL unmask_first got=%0d exp=2", oFIRST_ZONE); end
      iMASK = 3'b100;
      gap(2);
      checks++;
      if (oZONE_LATCHED !== 3'b100) begin failures++; $display("FAIL remask_keep got=%b exp=100", oZONE_LATCHED); end
   endtask

   task automatic test_clear_relatch();
      iZONE = 3'b001;
      gap(3);
      ticks(4);
      checks++;
      if (oZONE_LATCHED !== 3'b101) begin failures++; $display("FAIL pre_clear got=%b exp=101", oZONE_LATCHED); end
      iMASK = 3'b000;
      iCLEAR = 1'b1;
      gap(1);
      checks++;
      if (oZONE_LATCHED !== 3'b000 || oFIRST_VALID !== 1'b0 || oFIRST_ZONE !== 2'd0) begin
         failures++; $display("FAIL clear_edge got=%b/%b/%0d exp=000/0/0", oZONE_LATCHED, oFIRST_VALID, oFIRST_ZONE);
      end
      iCLEAR = 1'b0;
      gap(1);
      checks++;
      if (oZONE_LATCHED !== 3'b001 || oTRIP !== 1'b1) begin
         failures++; $display("FAIL relatch got=%b/%b exp=001/1", oZONE_LATCHED, oTRIP);
      end
      checks++;
      if (oFIRST_VALID !== 1'b1 || oFIRST_ZONE !== 2'd0) begin
         failures++; $display("FAIL relatch_first got=%b/%0d exp=1/0", oFIRST_VALID, oFIRST_ZONE);
      end
      iZONE = 3'b000;
      gap(3);
      ticks(4);
      iCLEAR = 1'b1;
      gap(1);
      iCLEAR = 1'b0;
      t0 = trip_count;
      gap(2);
      checks++;
      if (oZONE_LATCHED !== 3'b000 || oFIRST_VALID !== 1'b0 || trip_count !== t0) begin
         failures++; $display("FAIL clear_closed got=%b/%b/%0d exp=000/0/%0d", oZONE_LATCHED, oFIRST_VALID, trip_count, t0);
      end
   endtask

   task automatic test_reset_mid();
      iZONE = 3'b010;
      gap(3);
      ticks(4);
      checks++;
      if (oZONE_LATCHED !== 3'b010) begin failures++; $display("FAIL rst_pre_latch got=%b exp=010", oZONE_LATCHED); end
      iZONE = 3'b011;
      gap(3);
      ticks(2);
      #2;
      iRST = 1'b0;
      #1;
      checks++;
      if (oZONE_STABLE !== 3'b000 || oZONE_LATCHED !== 3'b000) begin
         failures++; $display("FAIL rst_async got=%b/%b exp=000/000", oZONE_STABLE, oZONE_LATCHED);
      end
      checks++;
      if (oTRIP !== 1'b0 || oFIRST_VALID !== 1'b0 || oFIRST_ZONE !== 2'd0) begin
         failures++; $display("FAIL rst_async_first got=%b/%b/%0d exp=0/0/0", oTRIP, oFIRST_VALID, oFIRST_ZONE);
      end
      @(negedge iCLK);
      iRST = 1'b1;
      gap(3);
      ticks(3);
      checks++;
      if (oZONE_STABLE !== 3'b000) begin failures++; $display("FAIL rst_requal_early got=%b exp=000", oZONE_STABLE); end
      do_tick();
      checks++;
      if (oZONE_STABLE !== 3'b011) begin failures++; $display("FAIL rst_requal got=%b exp=011", oZONE_STABLE); end
      gap(1);
      checks++;
      if (oZONE_LATCHED !== 3'b011 || oFIRST_ZONE !== 2'd0) begin
         failures++; $display("FAIL rst_requal_latch got=%b/%0d exp=011/0", oZONE_LATCHED, oFIRST_ZONE);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_simultaneous();
      test_mask();
      test_clear_relatch();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
